// File: rtl/vec_div_unit_if.sv
// Handshake and operand bundle for vec_div_unit.
// dz_flags exists only when DIV_ZERO_FLAG_EN is defined.
`timescale 1ns/1ps
interface vec_div_unit_if;
  logic        start;
  logic [0:5]  Op_code;
  logic [0:5]  R_ins;
  logic [0:1]  WW;
  logic [0:63] rA_64bit_val;
  logic [0:63] rB_64bit_val;
  logic        busy;
  logic        done;
  logic [0:63] div_out;
`ifdef DIV_ZERO_FLAG_EN
  logic [0:7]  dz_flags;

  modport master (
    output start, Op_code, R_ins, WW, rA_64bit_val, rB_64bit_val,
    input  busy, done, div_out, dz_flags
  );
  modport slave (
    input  start, Op_code, R_ins, WW, rA_64bit_val, rB_64bit_val,
    output busy, done, div_out, dz_flags
  );
`else
  modport master (
    output start, Op_code, R_ins, WW, rA_64bit_val, rB_64bit_val,
    input  busy, done, div_out
  );
  modport slave (
    input  start, Op_code, R_ins, WW, rA_64bit_val, rB_64bit_val,
    output busy, done, div_out
  );
`endif
endinterface

// File: rtl/vec_div_unit.sv
// Iterative restoring radix-2 unsigned vector divider (VDIV/VMOD), lanes 8/16/32/64.
// Optional per-lane divide-by-zero flags are enabled by defining DIV_ZERO_FLAG_EN.
`timescale 1ns/1ps
module vec_div_unit (
  input logic           clk,
  input logic           rst_n,
  vec_div_unit_if.slave bus
);
  localparam logic [5:0] R_ALU = 6'b101010;
  localparam logic [5:0] VDIV  = 6'b001110;
  localparam logic [5:0] VMOD  = 6'b001111;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [63:0] rem_q, quo_q, dvs_q;
  logic [63:0] rem_nxt, quo_nxt;
  logic [63:0] div_out_q;
  logic [127:0] st;
  logic [1:0]  ww_q;
  logic [6:0]  cnt_q;
  logic        is_mod_q;
  logic        busy_q, done_q;
  logic        accept;

  function automatic logic [6:0] lane_bits(input logic [1:0] ww);
    case (ww)
      2'b00:   return 7'd8;
      2'b01:   return 7'd16;
      2'b10:   return 7'd32;
      default: return 7'd64;
    endcase
  endfunction

  // One restoring step on a zero-extended lane; the shifted remainder keeps a
  // carry bit so divisors above half the lane range still compare correctly.
  function automatic logic [127:0] lane_step(input logic [63:0] r, q, d,
                                             input int unsigned w);
    logic [64:0] t;
    logic [63:0] mask;
    logic        ge;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    t    = {r, q[6'(w - 1)]};
    ge   = (t >= {1'b0, d});
    if (ge) t = t - {1'b0, d};
    return {t[63:0] & mask, ((q << 1) & mask) | {63'd0, ge}};
  endfunction

  assign accept = (state_q == IDLE) && bus.start && (bus.Op_code == R_ALU) &&
                  ((bus.R_ins == VDIV) || (bus.R_ins == VMOD));

  // NOTE: every variable written in a combinational block gets a default first,
  // otherwise an unassigned path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (cnt_q == 7'd1) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lanes never exchange bits: each slice steps independently.
  always_comb begin
    rem_nxt = rem_q;
    quo_nxt = quo_q;
    st      = '0;
    case (ww_q)
      2'b00: for (int l = 0; l < 8; l++) begin
        st = lane_step(64'(rem_q[l*8 +: 8]), 64'(quo_q[l*8 +: 8]), 64'(dvs_q[l*8 +: 8]), 8);
        rem_nxt[l*8 +: 8] = st[71:64];
        quo_nxt[l*8 +: 8] = st[7:0];
      end
      2'b01: for (int l = 0; l < 4; l++) begin
        st = lane_step(64'(rem_q[l*16 +: 16]), 64'(quo_q[l*16 +: 16]), 64'(dvs_q[l*16 +: 16]), 16);
        rem_nxt[l*16 +: 16] = st[79:64];
        quo_nxt[l*16 +: 16] = st[15:0];
      end
      2'b10: for (int l = 0; l < 2; l++) begin
        st = lane_step(64'(rem_q[l*32 +: 32]), 64'(quo_q[l*32 +: 32]), 64'(dvs_q[l*32 +: 32]), 32);
        rem_nxt[l*32 +: 32] = st[95:64];
        quo_nxt[l*32 +: 32] = st[31:0];
      end
      default: begin
        st      = lane_step(rem_q, quo_q, dvs_q, 64);
        rem_nxt = st[127:64];
        quo_nxt = st[63:0];
      end
    endcase
  end

`ifdef DIV_ZERO_FLAG_EN
  logic [0:7] dz_q, dz_nxt;

  // Flag bit i tracks lane i counted from the MSB end of the vector.
  always_comb begin
    dz_nxt = '0;
    case (ww_q)
      2'b00:   for (int i = 0; i < 8; i++) dz_nxt[i] = (dvs_q[(7-i)*8 +: 8] == '0);
      2'b01:   for (int i = 0; i < 4; i++) dz_nxt[i] = (dvs_q[(3-i)*16 +: 16] == '0);
      2'b10:   for (int i = 0; i < 2; i++) dz_nxt[i] = (dvs_q[(1-i)*32 +: 32] == '0);
      default: dz_nxt[0] = (dvs_q == '0);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                dz_q <= '0;
    else if (state_q == DONE)  dz_q <= dz_nxt;
  end

  assign bus.dz_flags = dz_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      div_out_q <= '0;
      ww_q      <= '0;
      cnt_q     <= '0;
      is_mod_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          rem_q    <= '0;
          quo_q    <= bus.rA_64bit_val;
          dvs_q    <= bus.rB_64bit_val;
          ww_q     <= bus.WW;
          is_mod_q <= (bus.R_ins == VMOD);
          cnt_q    <= lane_bits(bus.WW);
          busy_q   <= 1'b1;
        end
        RUN: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt_q <= cnt_q - 7'd1;
        end
        DONE: begin
          div_out_q <= is_mod_q ? rem_q : quo_q;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.div_out = div_out_q;
endmodule

// File: tb/tb_vec_div_unit.sv
// Self-checking bench for vec_div_unit: vector table, scoreboard and corner sequences.
`timescale 1ns/1ps
module tb_vec_div_unit;
  localparam logic [5:0] R_ALU = 6'b101010;
  localparam logic [5:0] VDIV  = 6'b001110;
  localparam logic [5:0] VMOD  = 6'b001111;
  localparam logic [5:0] LOAD  = 6'b100000;

  typedef struct {
    logic [1:0]  ww;
    logic [5:0]  ins;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] q;
    logic [7:0]  dz;
  } vec_t;

  typedef struct {
    logic [63:0] q;
    logic [7:0]  dz;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [63:0] last_out = '0;
  vec_t vecs[10];

  vec_div_unit_if bus();

  vec_div_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v, input logic [5:0] opc);
    bus.start        = 1'b1;
    bus.Op_code      = opc;
    bus.R_ins        = v.ins;
    bus.WW           = v.ww;
    bus.rA_64bit_val = v.a;
    bus.rB_64bit_val = v.b;
  endtask

  // Called at a negedge; accepts on the next posedge and returns at the
  // negedge where done is observed (or after the cycle budget expires).
  task automatic run_op(input vec_t v, input int inject_at);
    exp_t e;
    int   lat;
    int   bcnt;
    int   n;
    n = 8 << v.ww;
    drive(v, R_ALU);
    e.q  = v.q;
    e.dz = v.dz;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_accept", 64'(bus.busy), 64'd1);
    check("done_one_cycle", 64'(bus.done), 64'd0);
    check("div_out_hold", bus.div_out, last_out);
    lat  = 0;
    bcnt = 1;
    while (!bus.done && lat < 200) begin
      if (lat == inject_at) begin
        bus.start        = 1'b1;
        bus.R_ins        = (v.ins == VDIV) ? VMOD : VDIV;
        bus.rA_64bit_val = ~v.a;
        bus.rB_64bit_val = 64'h0101_0101_0101_0101;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
      if (bus.busy) bcnt++;
    end
    bus.start = 1'b0;
    check("done_seen", 64'(bus.done), 64'd1);
    check("latency", 64'(lat), 64'(n + 1));
    check("busy_cycles", 64'(bcnt), 64'(n + 1));
    check("busy_low_at_done", 64'(bus.busy), 64'd0);
    if (bus.done && sb.size() > 0) begin
      e = sb.pop_front();
      check("div_out", bus.div_out, e.q);
`ifdef DIV_ZERO_FLAG_EN
      check("dz_flags", 64'(bus.dz_flags), 64'(e.dz));
`endif
      last_out = e.q;
    end else begin
      sb.delete();
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int dcnt;
    vecs[0] = '{2'b00, VDIV, 64'h6464_6464_6464_6464, 64'h0707_0707_0707_0707, 64'h0E0E_0E0E_0E0E_0E0E, 8'h00};
    vecs[1] = '{2'b01, VMOD, 64'h03E8_03E8_03E8_03E8, 64'h0007_0007_0007_0007, 64'h0006_0006_0006_0006, 8'h00};
    vecs[2] = '{2'b10, VDIV, 64'h0000_0005_0000_000A, 64'h0000_0000_0000_0003, 64'hFFFF_FFFF_0000_0003, 8'h80};
    vecs[3] = '{2'b11, VDIV, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0002, 64'h7FFF_FFFF_FFFF_FFFF, 8'h00};
    vecs[4] = '{2'b00, VMOD, 64'hFFC8_1000_0780_FF05, 64'hC8C8_0305_0081_01FF, 64'h3700_0100_0780_0005, 8'h08};
    vecs[5] = '{2'b00, VDIV, 64'hFFC8_1000_0780_FF05, 64'hC8C8_0305_0081_01FF, 64'h0101_0500_FF00_FF00, 8'h08};
    vecs[6] = '{2'b01, VDIV, 64'hFFFF_8000_1234_0000, 64'h8001_0000_0010_0001, 64'h0001_FFFF_0123_0000, 8'h40};
    vecs[7] = '{2'b11, VMOD, 64'h0123_4567_89AB_CDEF, 64'h0000_0001_0000_0000, 64'h0000_0000_89AB_CDEF, 8'h00};
    vecs[8] = '{2'b11, VDIV, 64'h0123_4567_89AB_CDEF, 64'h0000_0001_0000_0000, 64'h0000_0000_0123_4567, 8'h00};
    vecs[9] = '{2'b10, VMOD, 64'hFFFF_FFFF_0000_0064, 64'h8000_0001_0000_0000, 64'h7FFF_FFFE_0000_0064, 8'h40};

    bus.start        = 1'b0;
    bus.Op_code      = '0;
    bus.R_ins        = '0;
    bus.WW           = '0;
    bus.rA_64bit_val = '0;
    bus.rB_64bit_val = '0;

    #1;
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_div_out", bus.div_out, 64'd0);
`ifdef DIV_ZERO_FLAG_EN
    check("reset_dz_flags", 64'(bus.dz_flags), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back table ops, each accepted at the earliest edge after done.
    for (int i = 0; i < 10; i++) run_op(vecs[i], -1);

    // New start with different operands during RUN cycle 3 must be ignored.
    run_op(vecs[0], 3);

    // Non-R_ALU opcode and unsupported R_ins are never accepted.
    drive(vecs[1], LOAD);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("load_not_accepted", 64'(bus.busy), 64'd0);
      check("load_out_hold", bus.div_out, last_out);
    end
    bus.Op_code = R_ALU;
    bus.R_ins   = 6'b000001;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("bad_rins_not_accepted", 64'(bus.busy), 64'd0);
      check("done_stays_low", 64'(bus.done), 64'd0);
    end
    bus.start = 1'b0;
    @(negedge clk);

    // Asynchronous reset at RUN cycle 5 of a 64-bit op aborts it.
    drive(vecs[3], R_ALU);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_div_out", bus.div_out, 64'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    last_out = '0;
    dcnt     = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    check("no_done_after_abort", 64'(dcnt), 64'd0);

    run_op(vecs[2], -1);
    run_op(vecs[3], -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
